// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga RV32I pipeline.
// Fetch-stage additions: the fetch-to-decode bundle, the fetch FSM states and the canonical NOP.
package tartaruga_pkg;

  localparam int IMEM_POS = 4096;

  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;

  localparam instruction_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    bus32_t       pc;
    instruction_t instr;
    logic         valid;
  } fetch_to_decode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_instr_mem.sv
// Single-clock instruction RAM: one write port for the loader, one synchronous read port.
// A read and a write to the same word in one cycle return the old contents.
module instr_mem
   import tartaruga_pkg::*;
#(
   parameter int    DEPTH     = 4096,
   parameter string INIT_FILE = "",
   localparam int   AW        = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  instruction_t  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output instruction_t  rdata_o
);

   instruction_t mem [DEPTH];

   // Loader write and gated synchronous read share the clock; nonblocking updates give old-data reads.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline front end: PC register, fetch FSM and the fetch-to-decode output register.
// Redirects arrive from writeback; a misaligned target or an out-of-range PC faults permanently.
module fetch_stage
  import tartaruga_pkg::*;
#(
  parameter int     IMEM_POS       = tartaruga_pkg::IMEM_POS,
  parameter bus32_t RESET_PC       = 32'h0000_0000,
  parameter string  IMEM_INIT_FILE = ""
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic                        stall_i,
  input  logic                        branch_taken_i,
  input  bus32_t                      branched_pc_i,
  input  logic                        imem_we_i,
  input  logic [$clog2(IMEM_POS)-1:0] imem_waddr_i,
  input  instruction_t                imem_wdata_i,
  output fetch_to_decode_t            fetch_o,
  output logic                        fault_o,
  output bus32_t                      pc_o
);

  localparam int     AW         = $clog2(IMEM_POS);
  localparam bus32_t IMEM_BYTES = bus32_t'(IMEM_POS * 4);

  fetch_state_t state;
  bus32_t       pc_q;
  bus32_t       out_pc;
  logic         out_valid;
  logic         fault_q;
  logic         instr_live;
  instruction_t ram_rdata;

  logic in_range;
  logic misaligned;
  logic do_fetch;

  assign in_range   = pc_q < IMEM_BYTES;
  assign misaligned = branched_pc_i[1:0] != 2'b00;
  assign do_fetch   = (state == RUN) && !branch_taken_i && !stall_i && in_range;

  // The RAM read register doubles as the instr field, so the read is enabled only on a
  // real fetch; that keeps the instruction frozen through stalls.
  instr_mem #(
    .DEPTH     (IMEM_POS),
    .INIT_FILE (IMEM_INIT_FILE)
  ) u_imem (
    .clk_i   (clk_i),
    .we_i    (imem_we_i),
    .waddr_i (imem_waddr_i),
    .wdata_i (imem_wdata_i),
    .re_i    (do_fetch),
    .raddr_i (pc_q[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      out_pc     <= '0;
      out_valid  <= 1'b0;
      fault_q    <= 1'b0;
      instr_live <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (start_i) state <= RUN;
        end
        RUN: begin
          if (branch_taken_i && misaligned) begin
            state     <= HALT;
            fault_q   <= 1'b1;
            out_valid <= 1'b0;
          end else if (branch_taken_i) begin
            pc_q      <= branched_pc_i;
            out_valid <= 1'b0;
          end else if (!stall_i) begin
            if (!in_range) begin
              state     <= HALT;
              fault_q   <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              out_pc     <= pc_q;
              out_valid  <= 1'b1;
              instr_live <= 1'b1;
              pc_q       <= pc_q + 32'd4;
            end
          end
        end
        HALT: begin
          out_valid <= 1'b0;
          fault_q   <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

  // Until the first fetch after reset the RAM register holds nothing meaningful; show a NOP.
  assign fetch_o.pc    = out_pc;
  assign fetch_o.instr = instr_live ? ram_rdata : NOP_INSTR;
  assign fetch_o.valid = out_valid;
  assign fault_o       = fault_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner sequences,
// and randomized traffic compared against an instruction-level reference model.
module tb_fetch_stage;
  import tartaruga_pkg::*;

  localparam int DEPTH       = 4096;
  localparam int SMALL_DEPTH = 16;
  localparam int MODE_IDLE   = 0;
  localparam int MODE_RUN    = 1;
  localparam int MODE_HALT   = 2;

  logic             clk;
  logic             rstn, start, stall, br, we;
  logic [31:0]      bpc, wdata;
  logic [11:0]      waddr;
  fetch_to_decode_t fetch;
  logic             fault;
  logic [31:0]      pco;

  logic             s_rstn, s_start, s_stall, s_br, s_we;
  logic [31:0]      s_bpc, s_wdata;
  logic [3:0]       s_waddr;
  fetch_to_decode_t s_fetch;
  logic             s_fault;
  logic [31:0]      s_pco;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: architectural view of the fetch unit.
  int          m_mode;
  logic [31:0] m_pc, m_fpc, m_finstr;
  logic        m_fvalid, m_fault, m_fknown;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  typedef struct {
    logic        start;
    logic        stall;
    logic        br;
    logic [31:0] bpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pcq;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [13];

  fetch_stage dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .start_i        (start),
    .stall_i        (stall),
    .branch_taken_i (br),
    .branched_pc_i  (bpc),
    .imem_we_i      (we),
    .imem_waddr_i   (waddr),
    .imem_wdata_i   (wdata),
    .fetch_o        (fetch),
    .fault_o        (fault),
    .pc_o           (pco)
  );

  fetch_stage #(.IMEM_POS(SMALL_DEPTH)) dut_small (
    .clk_i          (clk),
    .rstn_i         (s_rstn),
    .start_i        (s_start),
    .stall_i        (s_stall),
    .branch_taken_i (s_br),
    .branched_pc_i  (s_bpc),
    .imem_we_i      (s_we),
    .imem_waddr_i   (s_waddr),
    .imem_wdata_i   (s_wdata),
    .fetch_o        (s_fetch),
    .fault_o        (s_fault),
    .pc_o           (s_pco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    m_mode   = MODE_IDLE;
    m_pc     = 32'h0;
    m_fpc    = 32'h0;
    m_finstr = 32'h0000_0013;
    m_fvalid = 1'b0;
    m_fault  = 1'b0;
    m_fknown = 1'b1;
  endtask

  // One clock edge of the specified behaviour; the fetch reads memory before the loader write lands.
  task automatic modelEdge(input logic st, input logic sl, input logic b, input logic [31:0] bp,
                           input logic w, input logic [11:0] wa, input logic [31:0] wd);
    if (m_mode == MODE_IDLE) begin
      if (st) m_mode = MODE_RUN;
    end else if (m_mode == MODE_RUN) begin
      if (b && bp[1:0] != 2'b00) begin
        m_mode = MODE_HALT; m_fault = 1'b1; m_fvalid = 1'b0;
      end else if (b) begin
        m_pc = bp; m_fvalid = 1'b0;
      end else if (!sl) begin
        if (m_pc >= 32'(4 * DEPTH)) begin
          m_mode = MODE_HALT; m_fault = 1'b1; m_fvalid = 1'b0;
        end else begin
          m_fpc    = m_pc;
          m_finstr = m_mem[m_pc[13:2]];
          m_fknown = m_known[m_pc[13:2]];
          m_fvalid = 1'b1;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
    if (w) begin
      m_mem[wa]   = wd;
      m_known[wa] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sl, input logic b, input logic [31:0] bp,
                               input logic w, input logic [11:0] wa, input logic [31:0] wd);
    start = st; stall = sl; br = b; bpc = bp; we = w; waddr = wa; wdata = wd;
    @(posedge clk);
    modelEdge(st, sl, b, bp, w, wa, wd);
    #1;
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "_valid"}, 32'(fetch.valid), 32'(m_fvalid));
    checkOutput({tag, "_fault"}, 32'(fault), 32'(m_fault));
    checkOutput({tag, "_pc_o"}, pco, m_pc);
    if (m_fvalid) begin
      checkOutput({tag, "_pc"}, fetch.pc, m_fpc);
      if (m_fknown) checkOutput({tag, "_instr"}, fetch.instr, m_finstr);
    end
  endtask

  // Drops reset between clock edges and checks that the outputs clear without waiting for an edge.
  task automatic asyncReset();
    start = 1'b0; stall = 1'b0; br = 1'b0; we = 1'b0;
    #1 rstn = 1'b0;
    #1;
    resetModel();
    checkOutput("rst_valid", 32'(fetch.valid), 32'h0);
    checkOutput("rst_instr", fetch.instr, 32'h0000_0013);
    checkOutput("rst_pc", fetch.pc, 32'h0);
    checkOutput("rst_pc_o", pco, 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic smallStep(input logic st, input logic b, input logic [31:0] bp,
                           input logic w, input logic [3:0] wa, input logic [31:0] wd);
    s_start = st; s_br = b; s_bpc = bp; s_we = w; s_waddr = wa; s_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] preload [4];
    preload[0] = 32'h11; preload[1] = 32'h22; preload[2] = 32'h33; preload[3] = 32'h44;

    rstn = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; bpc = '0; we = 1'b0; waddr = '0; wdata = '0;
    s_rstn = 1'b0; s_start = 1'b0; s_stall = 1'b0; s_br = 1'b0; s_bpc = '0; s_we = 1'b0;
    s_waddr = '0; s_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 32'h0;
      m_known[i] = 1'b0;
    end
    resetModel();
    @(posedge clk);
    #1 rstn = 1'b1; s_rstn = 1'b1;
    asyncReset();

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 12'(i), preload[i]);
    applyStimulus(0, 0, 0, 0, 1, 12'd16, 32'hDEAD_0010);
    applyStimulus(0, 0, 0, 0, 1, 12'd17, 32'hDEAD_0011);

    // Straight-line fetch, 3-cycle stall at pc=4, redirect beating stall, plain redirect.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,          32'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 32'h11,         32'h04, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04, 32'h22,         32'h08, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'h22,         32'h08, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'h22,         32'h08, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 32'h22,         32'h08, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h33,         32'h0C, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h44,         32'h10, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h00, 32'h0,          32'h40, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h40, 32'hDEAD_0010,  32'h44, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h44, 32'hDEAD_0011,  32'h48, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h00, 32'h0,          32'h08, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'h33,         32'h0C, 1'b0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stall, vecs[i].br, vecs[i].bpc, 0, 0, 0);
      checkOutput($sformatf("vec%0d_valid", i), 32'(fetch.valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_pc_o", i), pco, vecs[i].exp_pcq);
      checkOutput($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_pc", i), fetch.pc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d_instr", i), fetch.instr, vecs[i].exp_instr);
      end
    end

    // Reset while a valid fetch is on the output, then restart: memory must survive.
    asyncReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("restart_valid", 32'(fetch.valid), 32'h1);
    checkOutput("restart_pc", fetch.pc, 32'h0);
    checkOutput("restart_instr", fetch.instr, 32'h11);

    // Misaligned redirect faults and stays faulted whatever arrives afterwards.
    applyStimulus(0, 0, 1, 32'h42, 0, 0, 0);
    checkOutput("misalign_valid", 32'(fetch.valid), 32'h0);
    checkOutput("misalign_fault", 32'(fault), 32'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, logic'(i % 2), 32'h40, 0, 0, 0);
      checkOutput($sformatf("halt%0d_valid", i), 32'(fetch.valid), 32'h0);
      checkOutput($sformatf("halt%0d_fault", i), 32'(fault), 32'h1);
    end
    asyncReset();

    // Small memory: the last word fetches once, the next PC is out of range.
    smallStep(0, 0, 0, 1, 4'd15, 32'h0F0F_0F0F);
    smallStep(1, 0, 0, 0, 0, 0);
    smallStep(0, 1, 32'h3C, 0, 0, 0);
    checkOutput("oor_redirect_valid", 32'(s_fetch.valid), 32'h0);
    checkOutput("oor_redirect_pc_o", s_pco, 32'h3C);
    smallStep(0, 0, 0, 0, 0, 0);
    checkOutput("oor_last_valid", 32'(s_fetch.valid), 32'h1);
    checkOutput("oor_last_pc", s_fetch.pc, 32'h3C);
    checkOutput("oor_last_instr", s_fetch.instr, 32'h0F0F_0F0F);
    checkOutput("oor_last_fault", 32'(s_fault), 32'h0);
    for (int i = 0; i < 3; i++) begin
      smallStep(1, 0, 0, 0, 0, 0);
      checkOutput($sformatf("oor_halt%0d_valid", i), 32'(s_fetch.valid), 32'h0);
      checkOutput($sformatf("oor_halt%0d_fault", i), 32'(s_fault), 32'h1);
    end

    // Randomized traffic against the reference model.
    asyncReset();
    for (int i = 0; i < 64; i++) applyStimulus(0, 0, 0, 0, 1, 12'(i), $urandom);
    applyStimulus(0, 0, 0, 0, 1, 12'd4094, $urandom);
    applyStimulus(0, 0, 0, 0, 1, 12'd4095, $urandom);
    for (int i = 0; i < 600; i++) begin
      logic        r_st, r_sl, r_b, r_w;
      logic [31:0] r_bp;
      int          r;
      if (i % 75 == 74) begin
        asyncReset();
      end else begin
        r    = int'($urandom_range(0, 99));
        r_st = ($urandom_range(0, 4) == 0);
        r_sl = ($urandom_range(0, 3) == 0);
        r_b  = (r < 10);
        r_bp = 32'($urandom_range(0, 63)) << 2;
        if (r == 8) r_bp = r_bp | 32'($urandom_range(1, 3));
        if (r == 9) r_bp = 32'd16376;
        r_w  = ($urandom_range(0, 2) == 0);
        applyStimulus(r_st, r_sl, r_b, r_bp, r_w, 12'($urandom_range(0, 63)), $urandom);
        checkAgainstModel($sformatf("rand%0d", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
